// File: rtl/enc_dec_pkg.sv
// ----------------------------------------------------------------------------
// enc_dec_pkg
// Shared Hamming SECDED layout helpers for the encoder and decoder paths.
// Both sides derive parity count, codeword width and data-bit placement from
// these functions, so the two paths always agree on the layout.
//
// Codeword layout (index i = Hamming position i):
//   bit 0                : overall even parity over bits 1..CW-1
//   bits at 1,2,4,8,..   : Hamming parity bits
//   remaining positions  : data bits, ascending, data[0] at position 3
// ----------------------------------------------------------------------------
package enc_dec_pkg;

    localparam int MIN_DATA_DEPTH = 4;
    localparam int MAX_DATA_DEPTH = 64;

    // Smallest P such that 2**P >= d + P + 1.
    function automatic int par_bits(input int d);
        int p;
        p = 1;
        while ((1 << p) < (d + p + 1)) begin
            p++;
        end
        return p;
    endfunction

    // True for 1, 2, 4, 8, ... (the parity positions).
    function automatic bit is_pow2(input int i);
        return (i > 0) && ((i & (i - 1)) == 0);
    endfunction

    // Full SECDED codeword width: data + Hamming parity + overall parity.
    function automatic int cw_width(input int d);
        return d + par_bits(d) + 1;
    endfunction

    // Hamming position of data bit j (j-th non-power-of-two position >= 3).
    function automatic int data_pos(input int j);
        int n;
        n = 0;
        for (int i = 3; i < 2 * MAX_DATA_DEPTH; i++) begin
            if (!is_pow2(i)) begin
                if (n == j) begin
                    return i;
                end
                n++;
            end
        end
        return 0;
    endfunction

endpackage : enc_dec_pkg

// File: rtl/enc_hamming_calc.sv
// ----------------------------------------------------------------------------
// enc_hamming_calc
// Purely combinational Hamming SECDED encoder: scatters the data word into its
// codeword positions, builds the per-position parity XOR trees and appends the
// overall even-parity bit at index 0.
//
// Ports:
//   i_data  [DATA_DEPTH-1:0]  data word to encode
//   o_cw    [CW_WIDTH-1:0]    encoded codeword (no error injection here)
// ----------------------------------------------------------------------------
module enc_hamming_calc
    import enc_dec_pkg::*;
#(
    parameter  int DATA_DEPTH = 8,
    localparam int PAR_BITS   = par_bits(DATA_DEPTH),
    localparam int CW_WIDTH   = cw_width(DATA_DEPTH),
    localparam int POS_W      = $clog2(CW_WIDTH)
) (
    input  logic [DATA_DEPTH-1:0] i_data,
    output logic [CW_WIDTH-1:0]   o_cw
);

    logic [CW_WIDTH-1:0] w_placed;  // data scattered, parity slots still zero
    logic [PAR_BITS-1:0] w_par;     // Hamming parity bits, w_par[k] -> position 2**k
    logic [CW_WIDTH-1:0] w_body;    // codeword without the overall parity bit

    // Data placement: positions are elaboration-time constants, so this is
    // pure wiring.
    always_comb begin
        // NOTE: every always_comb output gets a full default first; any path
        // that left a bit unassigned would infer a latch.
        w_placed = '0;
        for (int j = 0; j < DATA_DEPTH; j++) begin
            w_placed[POS_W'(data_pos(j))] = i_data[j];
        end
    end

    // Parity at 2**k covers every position whose index has bit k set. Parity
    // slots in w_placed are zero, so including them in the sweep is harmless.
    always_comb begin
        w_par = '0;
        for (int k = 0; k < PAR_BITS; k++) begin
            for (int i = 1; i < CW_WIDTH; i++) begin
                if (((i >> k) & 1) == 1) begin
                    // NOTE: blocking '=' here on purpose: the accumulator must
                    // see its own previous value within the same evaluation.
                    w_par[k] = w_par[k] ^ w_placed[i];
                end
            end
        end
    end

    always_comb begin
        w_body = w_placed;
        for (int k = 0; k < PAR_BITS; k++) begin
            w_body[POS_W'(1 << k)] = w_par[k];
        end
    end

    // Bit 0 makes the whole codeword even parity.
    assign o_cw = {w_body[CW_WIDTH-1:1], ^w_body[CW_WIDTH-1:1]};

endmodule : enc_hamming_calc

// File: rtl/enc_hamming_pipe.sv
// ----------------------------------------------------------------------------
// enc_hamming_pipe
// Transmit-side Hamming SECDED encoder. Two-stage valid/ready pipeline
// (S1 = input payload, S2 = encoded codeword), one word per cycle, full
// backpressure, optional single-bit error injection per word, and a wrapping
// count of completed output handshakes.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   input word valid
//   in_ready   block can accept an input word (combinational)
//   in_data    data word
//   inj_en     flip one codeword bit of this word (sampled with in_data)
//   inj_pos    index of the bit to flip; >= CW_WIDTH flips nothing
//   out_valid  codeword valid
//   out_ready  downstream accepts the codeword
//   out_cw     codeword
//   word_cnt   count of completed output handshakes, wraps
// ----------------------------------------------------------------------------
module enc_hamming_pipe
    import enc_dec_pkg::*;
#(
    parameter  int DATA_DEPTH = 8,
    parameter  int CNT_WIDTH  = 16,
    localparam int CW_WIDTH   = cw_width(DATA_DEPTH),
    localparam int POS_W      = $clog2(CW_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_DEPTH-1:0] in_data,
    input  logic                  inj_en,
    input  logic [POS_W-1:0]      inj_pos,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CW_WIDTH-1:0]   out_cw,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    // Stage 1: raw payload
    logic                  r_s1_v;
    logic [DATA_DEPTH-1:0] r_s1_data;
    logic                  r_s1_inj_en;
    logic [POS_W-1:0]      r_s1_inj_pos;

    // Stage 2: encoded codeword
    logic                  r_s2_v;
    logic [CW_WIDTH-1:0]   r_s2_cw;

    logic [CNT_WIDTH-1:0]  r_word_cnt;

    logic                  w_s1_adv;
    logic                  w_in_fire;
    logic                  w_s1_fire;
    logic                  w_out_fire;
    logic [CW_WIDTH-1:0]   w_enc_cw;
    logic [CW_WIDTH-1:0]   w_flip;

    // S1 may move forward whenever S2 is empty or being drained this cycle.
    // in_ready is derived combinationally from that so a full pipe still
    // streams one word per cycle without a bubble.
    assign w_s1_adv   = !r_s2_v || out_ready;
    assign in_ready   = !r_s1_v || w_s1_adv;
    assign w_in_fire  = in_valid && in_ready;
    assign w_s1_fire  = r_s1_v && w_s1_adv;
    assign w_out_fire = r_s2_v && out_ready;

    enc_hamming_calc #(
        .DATA_DEPTH (DATA_DEPTH)
    ) u_calc (
        .i_data (r_s1_data),
        .o_cw   (w_enc_cw)
    );

    // Injection mask: a single one-hot bit, or nothing when disabled or the
    // position lies beyond the codeword.
    assign w_flip = (r_s1_inj_en && (int'(r_s1_inj_pos) < CW_WIDTH))
                  ? (CW_WIDTH'(1) << r_s1_inj_pos)
                  : '0;

    // Valid flags, output codeword and counter: these define what the
    // outside world sees, so they are reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v     <= 1'b0;
            r_s2_v     <= 1'b0;
            r_s2_cw    <= '0;
            r_word_cnt <= '0;
        end else begin
            // NOTE: non-blocking '<=' for all state so every register samples
            // pre-edge values regardless of statement order.
            if (in_ready) begin
                r_s1_v <= in_valid;
            end
            if (w_s1_adv) begin
                r_s2_v <= r_s1_v;
            end
            if (w_s1_fire) begin
                r_s2_cw <= w_enc_cw ^ w_flip;
            end
            if (w_out_fire) begin
                r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // NOTE: the S1 payload is deliberately not reset; it is only ever consumed
    // under r_s1_v, so a reset term would just add fan-out on rst.
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_s1_data    <= in_data;
            r_s1_inj_en  <= inj_en;
            r_s1_inj_pos <= inj_pos;
        end
    end

    assign out_valid = r_s2_v;
    assign out_cw    = r_s2_cw;
    assign word_cnt  = r_word_cnt;

endmodule : enc_hamming_pipe

// File: tb/tb_enc_hamming_pipe.sv
// ----------------------------------------------------------------------------
// tb_enc_hamming_pipe
// Scoreboard bench for enc_hamming_pipe at DATA_DEPTH=8. The stimulus side
// pushes the reference codeword of every accepted word into a queue; an
// independent monitor pops and compares on every output handshake. A second
// instance with CNT_WIDTH=4 shares the same inputs to exercise counter wrap.
// ----------------------------------------------------------------------------
module tb_enc_hamming_pipe;

    localparam int DW = 8;
    localparam int CW = 13;
    localparam int PW = 4;

    typedef struct {
        logic [CW-1:0] cw;
        bit            inj;   // a bit really was flipped in this word
    } sb_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          inj_en = 1'b0;
    logic [PW-1:0] inj_pos = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_cw;
    logic [15:0]   word_cnt;

    logic          in_ready_c4;
    logic          out_valid_c4;
    logic [CW-1:0] out_cw_c4;
    logic [3:0]    word_cnt_c4;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mdl_cnt = 0;
    int last_acc_cyc = 0;
    sb_t sb[$];
    int out_cycles[$];

    enc_hamming_pipe #(.DATA_DEPTH(DW), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .inj_en(inj_en), .inj_pos(inj_pos),
        .out_valid(out_valid), .out_ready(out_ready), .out_cw(out_cw),
        .word_cnt(word_cnt)
    );

    enc_hamming_pipe #(.DATA_DEPTH(DW), .CNT_WIDTH(4)) dut_c4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_c4), .in_data(in_data),
        .inj_en(inj_en), .inj_pos(inj_pos),
        .out_valid(out_valid_c4), .out_ready(out_ready), .out_cw(out_cw_c4),
        .word_cnt(word_cnt_c4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference: data at non-power-of-two positions; the Hamming parity bits
    // together equal the XOR of the indices of all set data positions.
    function automatic logic [CW-1:0] ref_encode(input logic [DW-1:0] d, input bit ie, input int ip);
        logic [CW-1:0] cw;
        int j;
        int s;
        cw = '0;
        j = 0;
        s = 0;
        for (int pos = 1; pos < CW; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = d[j];
                if (d[j]) s = s ^ pos;
                j++;
            end
        end
        for (int k = 0; (1 << k) < CW; k++) cw[1 << k] = s[k];
        cw[0] = ^cw;
        if (ie && ip < CW) cw[ip] = ~cw[ip];
        return cw;
    endfunction

    // Decoder-side view: syndrome is the XOR of indices of set bits 1..CW-1.
    function automatic int syndrome(input logic [CW-1:0] cw);
        int s;
        s = 0;
        for (int i = 1; i < CW; i++) if (cw[i]) s = s ^ i;
        return s;
    endfunction

    // Monitor: sample on the falling edge, where the next rising edge's
    // handshake inputs are already stable.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_output");
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("out_cw", out_cw, e.cw);
                check("out_cw_c4", out_cw_c4, e.cw);
                if (!e.inj) begin
                    check("syndrome", syndrome(out_cw), 0);
                    check("overall_parity", ^out_cw, 0);
                end
            end
            mdl_cnt++;
            out_cycles.push_back(cyc);
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [DW-1:0] d, input bit ie, input logic [PW-1:0] ip,
                        input logic [CW-1:0] exp);
        bit done;
        sb_t e;
        done = 0;
        in_valid = 1'b1;
        in_data = d;
        inj_en = ie;
        inj_pos = ip;
        for (int t = 0; t < 1000 && !done; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.cw = exp;
                e.inj = ie && (int'(ip) < CW);
                sb.push_back(e);
                last_acc_cyc = cyc;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        inj_en = 1'b0;
        if (!done) fail_now("accept_timeout");
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while (sb.size() != 0 && t < 500) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (sb.size() != 0) begin
            fail_now("drain_timeout");
            sb.delete();
        end
        repeat (2) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        inj_en = 1'b0;
        out_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        sb.delete();
        mdl_cnt = 0;
        rst = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] w[4];
        logic [PW-1:0] ip;
        bit ie;
        bit rnd_done;
        int a0;

        // Reset state
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_cw", out_cw, 0);
        check("rst_word_cnt", word_cnt, 0);
        check("rst_in_ready", in_ready, 1);

        // 1: three words back to back, known codewords, latency 2
        out_ready = 1'b1;
        out_cycles.delete();
        send(8'h00, 0, '0, 13'h0000);
        a0 = last_acc_cyc;
        send(8'hA5, 0, '0, 13'h144E);
        send(8'hFF, 0, '0, 13'h1EEE);
        drain();
        check("t1_n_out", out_cycles.size(), 3);
        if (out_cycles.size() == 3) begin
            check("t1_latency", out_cycles[0] - a0, 2);
            check("t1_b2b_1", out_cycles[1] - out_cycles[0], 1);
            check("t1_b2b_2", out_cycles[2] - out_cycles[0], 2);
        end
        check("t1_word_cnt", word_cnt, 3);

        // 2: injection in range and out of range
        send(8'hA5, 1, 4'd5, 13'h146E);
        send(8'hA5, 1, 4'd13, 13'h144E);
        drain();

        // 3: backpressure with four queued words
        for (int i = 0; i < 4; i++) w[i] = DW'($urandom);
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) send(w[i], 0, '0, ref_encode(w[i], 0, 0));
            end
            begin
                repeat (5) begin @(posedge clk); #1; end
                @(negedge clk);
                check("t3_accepted", sb.size(), 2);
                check("t3_in_ready", in_ready, 0);
                check("t3_out_valid", out_valid, 1);
                check("t3_hold_a", out_cw, ref_encode(w[0], 0, 0));
                repeat (2) @(negedge clk);
                check("t3_hold_b", out_cw, ref_encode(w[0], 0, 0));
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("t3_word_cnt", word_cnt, 16'(mdl_cnt));

        // 4: reset with two words in flight
        out_ready = 1'b0;
        send(8'h3C, 0, '0, ref_encode(8'h3C, 0, 0));
        send(8'hC3, 0, '0, ref_encode(8'hC3, 0, 0));
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        check("t4_out_valid", out_valid, 0);
        check("t4_out_cw", out_cw, 0);
        check("t4_word_cnt", word_cnt, 0);
        rst = 1'b0;
        mdl_cnt = 0;
        out_ready = 1'b1;
        repeat (10) begin @(posedge clk); #1; end
        check("t4_no_emit", word_cnt, 0);

        // 5: random traffic and backpressure against the reference model
        rnd_done = 0;
        fork
            begin
                for (int n = 0; n < 10000; n++) begin
                    if ($urandom_range(0, 3) == 0)
                        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
                    d = DW'($urandom);
                    ie = ($urandom_range(0, 7) == 0);
                    ip = PW'($urandom_range(0, 15));
                    send(d, ie, ip, ref_encode(d, ie, int'(ip)));
                end
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();
        check("t5_word_cnt", word_cnt, 16'(mdl_cnt));
        check("t5_word_cnt_c4", word_cnt_c4, 4'(mdl_cnt));

        // 6: 4-bit counter wraps after 16 words
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            d = DW'($urandom);
            send(d, 0, '0, ref_encode(d, 0, 0));
        end
        drain();
        check("t6_word_cnt_c4", word_cnt_c4, 1);
        check("t6_word_cnt", word_cnt, 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_enc_hamming_pipe
